// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions for the issue/stall sequencer: state and
// exception-vector encodings plus a small constant helper.
package pipe_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int EXC_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    PC_RUN      = 3'd0,
    PC_MUL      = 3'd1,
    PC_AHB_WAIT = 3'd2,
    PC_FLUSH    = 3'd3,
    PC_EXC      = 3'd4
  } pc_state_e;

  typedef enum logic [EXC_W-1:0] {
    EXC_NONE  = 3'd0,
    EXC_UNDEF = 3'd1,
    EXC_SWI   = 3'd2,
    EXC_DABT  = 3'd3
  } exc_vec_e;

  // Larger of two constants; sizes the counter shared by MUL and FLUSH.
  function automatic int pc_max(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline controller and the fetch,
// decode, execute and AHB side of the core.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  // Toward the controller
  logic             fetch_valid;
  logic             dec_valid;
  logic             dec_mul_en;
  logic             dec_ahb_rd_en;
  logic             dec_ahb_wr_en;
  logic             dec_branch;
  logic             dec_swi;
  logic             dec_undef;
  logic             ahb_hready;
  logic             ahb_hresp;
  logic             exc_ack;

  // From the controller
  logic             fetch_en;
  logic             decode_en;
  logic             exec_en;
  logic             mul_start;
  logic             ahb_start;
  logic             flush;
  logic             exc_req;
  logic [EXC_W-1:0] exc_vec;
  logic             busy;

  // The controller itself
  modport master (
    input  fetch_valid, dec_valid, dec_mul_en, dec_ahb_rd_en, dec_ahb_wr_en,
           dec_branch, dec_swi, dec_undef, ahb_hready, ahb_hresp, exc_ack,
    output fetch_en, decode_en, exec_en, mul_start, ahb_start, flush,
           exc_req, exc_vec, busy
  );

  // The pipeline stages it sequences
  modport slave (
    output fetch_valid, dec_valid, dec_mul_en, dec_ahb_rd_en, dec_ahb_wr_en,
           dec_branch, dec_swi, dec_undef, ahb_hready, ahb_hresp, exc_ack,
    input  fetch_en, decode_en, exec_en, mul_start, ahb_start, flush,
           exc_req, exc_vec, busy
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Issue/stall sequencer: enables fetch/decode while running, stalls them
// through multiply and AHB load/store, flushes after branches and
// exceptions, and raises undefined/SWI/data-abort requests.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES   = 3,
  parameter int AHB_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.master bus
);

  localparam int CNT_MAX = pc_max(MUL_CYCLES, FLUSH_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TMO_W   = $clog2(AHB_TIMEOUT);

  localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(AHB_TIMEOUT - 1);

  pc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             br_q, br_d;
  exc_vec_e         exc_vec_q, exc_vec_d;

  logic fetch_en_q, fetch_en_d;
  logic decode_en_q, decode_en_d;
  logic mul_start_q, mul_start_d;
  logic ahb_start_q, ahb_start_d;
  logic flush_q, flush_d;
  logic exc_req_q, exc_req_d;
  logic busy_q, busy_d;

  // fetch_valid is already folded into dec_valid by the decoder
  logic unused_fetch_valid;
  assign unused_fetch_valid = bus.fetch_valid;

  // State register, counters and registered outputs; reset returns to RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PC_RUN;
      cnt_q       <= '0;
      tmo_q       <= '0;
      br_q        <= 1'b0;
      exc_vec_q   <= EXC_NONE;
      fetch_en_q  <= 1'b0;
      decode_en_q <= 1'b0;
      mul_start_q <= 1'b0;
      ahb_start_q <= 1'b0;
      flush_q     <= 1'b0;
      exc_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      br_q        <= br_d;
      exc_vec_q   <= exc_vec_d;
      fetch_en_q  <= fetch_en_d;
      decode_en_q <= decode_en_d;
      mul_start_q <= mul_start_d;
      ahb_start_q <= ahb_start_d;
      flush_q     <= flush_d;
      exc_req_q   <= exc_req_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: issue priority undef > swi > mul > ahb > branch in RUN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    br_d      = br_q;
    exc_vec_d = exc_vec_q;
    case (state_q)
      PC_RUN: begin
        if (bus.dec_valid) begin
          if (bus.dec_undef) begin
            state_d   = PC_EXC;
            exc_vec_d = EXC_UNDEF;
          end else if (bus.dec_swi) begin
            state_d   = PC_EXC;
            exc_vec_d = EXC_SWI;
          end else if (bus.dec_mul_en) begin
            state_d = PC_MUL;
            cnt_d   = MUL_LOAD;
            br_d    = bus.dec_branch;
          end else if (bus.dec_ahb_rd_en || bus.dec_ahb_wr_en) begin
            state_d = PC_AHB_WAIT;
            tmo_d   = '0;
            br_d    = bus.dec_branch;
          end else if (bus.dec_branch) begin
            state_d = PC_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end
      end
      PC_MUL: begin
        if (cnt_q == '0) begin
          state_d = br_q ? PC_FLUSH : PC_RUN;
          cnt_d   = FLUSH_LOAD;
          br_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PC_AHB_WAIT: begin
        // A completing transfer beats the timeout in the same cycle
        if (bus.ahb_hready) begin
          br_d = 1'b0;
          if (bus.ahb_hresp) begin
            state_d   = PC_EXC;
            exc_vec_d = EXC_DABT;
          end else begin
            state_d = br_q ? PC_FLUSH : PC_RUN;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = PC_EXC;
          exc_vec_d = EXC_DABT;
          br_d      = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      PC_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = PC_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PC_EXC: begin
        if (bus.exc_ack) begin
          state_d   = PC_FLUSH;
          cnt_d     = FLUSH_LOAD;
          exc_vec_d = EXC_NONE;
        end
      end
      default: begin
        state_d   = PC_RUN;
        exc_vec_d = EXC_NONE;
        br_d      = 1'b0;
      end
    endcase
  end

  // Registered outputs follow the state being entered; launches pulse on entry
  always_comb begin
    fetch_en_d  = (state_d == PC_RUN);
    decode_en_d = (state_d == PC_RUN);
    busy_d      = (state_d != PC_RUN);
    flush_d     = (state_d == PC_FLUSH);
    exc_req_d   = (state_d == PC_EXC);
    mul_start_d = (state_d == PC_MUL) && (state_q != PC_MUL);
    ahb_start_d = (state_d == PC_AHB_WAIT) && (state_q != PC_AHB_WAIT);
  end

  assign bus.fetch_en  = fetch_en_q;
  assign bus.decode_en = decode_en_q;
  assign bus.exec_en   = (state_q == PC_RUN) && bus.dec_valid;
  assign bus.mul_start = mul_start_q;
  assign bus.ahb_start = ahb_start_q;
  assign bus.flush     = flush_q;
  assign bus.exc_req   = exc_req_q;
  assign bus.exc_vec   = exc_vec_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Table-driven bench for pipe_ctrl: each record gives one cycle of inputs,
// the expected exec_en before the edge and registered outputs after it.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .MUL_CYCLES  (3),
    .AHB_TIMEOUT (16),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Input bits: {dv, undef, swi, mul, rd, wr, branch, hready, hresp, ack}
  localparam logic [9:0] I_NONE = 10'h000;
  localparam logic [9:0] I_DV   = 10'h200;
  localparam logic [9:0] I_UND  = 10'h100;
  localparam logic [9:0] I_SWI  = 10'h080;
  localparam logic [9:0] I_MUL  = 10'h040;
  localparam logic [9:0] I_RD   = 10'h020;
  localparam logic [9:0] I_WR   = 10'h010;
  localparam logic [9:0] I_BR   = 10'h008;
  localparam logic [9:0] I_HRDY = 10'h004;
  localparam logic [9:0] I_HRSP = 10'h002;
  localparam logic [9:0] I_ACK  = 10'h001;

  // Output bits: {fetch_en, decode_en, mul_start, ahb_start, flush, exc_req, busy, exc_vec[2:0]}
  localparam logic [9:0] O_ZERO  = 10'b0000000_000;
  localparam logic [9:0] O_RUN   = 10'b1100000_000;
  localparam logic [9:0] O_MULS  = 10'b0010001_000;
  localparam logic [9:0] O_AHBS  = 10'b0001001_000;
  localparam logic [9:0] O_BUSY  = 10'b0000001_000;
  localparam logic [9:0] O_FLUSH = 10'b0000101_000;
  localparam logic [9:0] O_EXC1  = 10'b0000011_001;
  localparam logic [9:0] O_EXC2  = 10'b0000011_010;
  localparam logic [9:0] O_EXC3  = 10'b0000011_011;

  typedef struct {
    logic [9:0] in;
    logic       exec;
    logic [9:0] out;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] sb_q[$];
  int         total = 0;
  int         bad   = 0;

  function automatic vec_t mk(logic [9:0] in, logic exec, logic [9:0] out);
    vec_t v;
    v.in   = in;
    v.exec = exec;
    v.out  = out;
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {bus.fetch_en, bus.decode_en, bus.mul_start, bus.ahb_start, bus.flush,
            bus.exc_req, bus.busy, bus.exc_vec};
  endfunction

  task automatic check(string name, logic [9:0] got, logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic drive(logic [9:0] in);
    bus.fetch_valid   = 1'b1;
    bus.dec_valid     = in[9];
    bus.dec_undef     = in[8];
    bus.dec_swi       = in[7];
    bus.dec_mul_en    = in[6];
    bus.dec_ahb_rd_en = in[5];
    bus.dec_ahb_wr_en = in[4];
    bus.dec_branch    = in[3];
    bus.ahb_hready    = in[2];
    bus.ahb_hresp     = in[1];
    bus.exc_ack       = in[0];
  endtask

  // One cycle: drive, check exec_en combinationally, clock, check registers
  task automatic step(string name, logic [9:0] in, logic exec, logic [9:0] out);
    logic [9:0] exp;
    drive(in);
    sb_q.push_back(out);
    #1;
    check({name, ".exec_en"}, {9'b0, bus.exec_en}, {9'b0, exec});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check(name, outs(), exp);
    $display("%s in=%b out=%b", name, in, outs());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ALU ops, multiply, 4-wait load, branch, exceptions, latched branches
    tbl.push_back(mk(I_DV,                        1'b1, O_RUN));
    tbl.push_back(mk(I_DV,                        1'b1, O_RUN));
    tbl.push_back(mk(I_NONE,                      1'b0, O_RUN));
    tbl.push_back(mk(I_DV | I_MUL,                1'b1, O_MULS));
    tbl.push_back(mk(I_DV,                        1'b0, O_BUSY));
    tbl.push_back(mk(I_NONE,                      1'b0, O_BUSY));
    tbl.push_back(mk(I_NONE,                      1'b0, O_RUN));
    tbl.push_back(mk(I_DV | I_RD,                 1'b1, O_AHBS));
    tbl.push_back(mk(I_NONE,                      1'b0, O_BUSY));
    tbl.push_back(mk(I_ACK,                       1'b0, O_BUSY));
    tbl.push_back(mk(I_NONE,                      1'b0, O_BUSY));
    tbl.push_back(mk(I_NONE,                      1'b0, O_BUSY));
    tbl.push_back(mk(I_HRDY,                      1'b0, O_RUN));
    tbl.push_back(mk(I_HRDY | I_HRSP | I_ACK,     1'b0, O_RUN));
    tbl.push_back(mk(I_DV | I_BR,                 1'b1, O_FLUSH));
    tbl.push_back(mk(I_DV | I_UND,                1'b0, O_FLUSH));
    tbl.push_back(mk(I_DV | I_SWI,                1'b0, O_RUN));
    tbl.push_back(mk(I_DV | I_UND | I_SWI | I_MUL, 1'b1, O_EXC1));
    tbl.push_back(mk(I_HRDY,                      1'b0, O_EXC1));
    tbl.push_back(mk(I_ACK,                       1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_RUN));
    tbl.push_back(mk(I_DV | I_SWI | I_MUL,        1'b1, O_EXC2));
    tbl.push_back(mk(I_ACK,                       1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_RUN));
    tbl.push_back(mk(I_DV | I_WR | I_BR,          1'b1, O_AHBS));
    tbl.push_back(mk(I_HRDY,                      1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_RUN));
    tbl.push_back(mk(I_DV | I_RD,                 1'b1, O_AHBS));
    tbl.push_back(mk(I_HRDY | I_HRSP,             1'b0, O_EXC3));
    tbl.push_back(mk(I_ACK,                       1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_RUN));
    tbl.push_back(mk(I_DV | I_MUL | I_BR,         1'b1, O_MULS));
    tbl.push_back(mk(I_NONE,                      1'b0, O_BUSY));
    tbl.push_back(mk(I_NONE,                      1'b0, O_BUSY));
    tbl.push_back(mk(I_NONE,                      1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_FLUSH));
    tbl.push_back(mk(I_NONE,                      1'b0, O_RUN));

    // Reset state
    drive(I_NONE);
    #12;
    check("reset.outs", outs(), O_ZERO);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exec, tbl[i].out);
    end

    // Load that never completes: data abort on the 16th wait cycle
    step("tmo.issue", I_DV | I_RD, 1'b1, O_AHBS);
    for (int i = 0; i < 15; i++) begin
      step($sformatf("tmo.wait%0d", i), I_NONE, 1'b0, O_BUSY);
    end
    step("tmo.abort", I_NONE, 1'b0, O_EXC3);
    step("tmo.hold",  I_NONE, 1'b0, O_EXC3);
    step("tmo.ack",   I_ACK,  1'b0, O_FLUSH);
    step("tmo.fl1",   I_NONE, 1'b0, O_FLUSH);
    step("tmo.run",   I_NONE, 1'b0, O_RUN);

    // hready arriving on the last allowed cycle beats the timeout
    step("race.issue", I_DV | I_RD, 1'b1, O_AHBS);
    for (int i = 0; i < 15; i++) begin
      step($sformatf("race.wait%0d", i), I_NONE, 1'b0, O_BUSY);
    end
    step("race.done", I_HRDY, 1'b0, O_RUN);

    // Asynchronous reset in the middle of AHB_WAIT
    step("arst.issue", I_DV | I_RD, 1'b1, O_AHBS);
    step("arst.wait",  I_NONE,      1'b0, O_BUSY);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.async", outs(), O_ZERO);
    @(posedge clk);
    #1;
    check("arst.held", outs(), O_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    step("arst.run", I_NONE, 1'b0, O_RUN);
    step("arst.alu", I_DV,   1'b1, O_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
